// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a {len_lo, len_hi, payload, xor} frame and writes the payload
// into instruction memory from address 0 through a registered byte write port.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 109,
    parameter int unsigned ADDR_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [7:0]        in_data_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   bytes_written_o
);

    localparam logic [15:0]     MaxLen = 16'(MEM_BYTES);
    localparam logic [ADDR_W:0] BwOne  = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCsum,
        StFinish,
        StFail
    } state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              error_q, error_d;
    logic [ADDR_W:0]   bytes_written_q, bytes_written_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;

    logic              accept;
    logic [ADDR_W:0]   bw_inc;
    logic [15:0]       len_new;

    assign accept  = in_valid_i && in_ready_q;
    assign bw_inc  = bytes_written_q + BwOne;
    assign len_new = {in_data_i, len_q[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            in_ready_q      <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            error_q         <= 1'b0;
            bytes_written_q <= '0;
            len_q           <= '0;
            csum_q          <= '0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            error_q         <= error_d;
            bytes_written_q <= bytes_written_d;
            len_q           <= len_d;
            csum_q          <= csum_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        error_d         = error_q;
        bytes_written_d = bytes_written_q;
        len_d           = len_q;
        csum_d          = csum_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    error_d         = 1'b0;
                    bytes_written_d = '0;
                    csum_d          = '0;
                    state_d         = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d[7:0] = in_data_i;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d[15:8] = in_data_i;
                    // Rejecting oversize frames here is what keeps every write below MEM_BYTES.
                    if (len_new > MaxLen) begin
                        error_d = 1'b1;
                        state_d = StFail;
                    end else if (len_new == 16'd0) begin
                        state_d = StCsum;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d          = csum_q ^ in_data_i;
                    mem_we_d        = 1'b1;
                    mem_addr_d      = bytes_written_q[ADDR_W-1:0];
                    mem_wdata_d     = in_data_i;
                    bytes_written_d = bw_inc;
                    if (16'(bw_inc) == len_q) begin
                        state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (in_data_i == csum_q) begin
                        state_d = StFinish;
                    end else begin
                        error_d = 1'b1;
                        state_d = StFail;
                    end
                end
            end
            StFinish: state_d = StIdle;
            StFail:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        in_ready_d = (state_d == StLenLo) || (state_d == StLenHi) ||
                     (state_d == StData)  || (state_d == StCsum);
    end

    assign in_ready_o      = in_ready_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign busy_o          = (state_q != StIdle);
    assign core_hold_o     = busy_o;
    assign done_o          = (state_q == StFinish) || (state_q == StFail);
    assign error_o         = error_q;
    assign bytes_written_o = bytes_written_q;

endmodule
